boid_sweep_ctrl: RTL and testbench

Sequencer for the boid-update datapath and the boid register memory. On each frame start it loops over every boid i. For each i it does four things: clears the datapath accumulators, streams every boid j out of memory into the datapath, triggers the final velocity/position update, and writes boid i back. It sits between the frame/VGA timing logic (start, stall) and the memory/datapath pair.

---
 rtl/boid_sweep_pkg.sv | 24 ++
 rtl/rd_valid_pipe.sv | 47 ++++
 rtl/boid_sweep_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_boid_sweep_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/boid_sweep_pkg.sv
// Shared types and helpers for the boid sweep sequencer.
// Holds the sequencer state encoding and the index-width function.
package boid_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SCAN   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_UPDATE = 3'd4,
        ST_WRITE  = 3'd5,
        ST_DONE   = 3'd6
    } sweep_state_t;

    // A single boid still needs a one-bit index.
    function automatic int idx_w(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rd_valid_pipe.sv
// Read-valid delay line matching the memory read latency.
// Carries a valid bit plus payload and reports reads still in flight.
module rd_valid_pipe #(
    parameter int RD_LAT = 2,
    parameter int PAY_W  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [PAY_W-1:0] in_pay,
    output logic             out_valid,
    output logic [PAY_W-1:0] out_pay,
    output logic             any_valid
);

    logic [RD_LAT-1:0] vld_r;
    logic [PAY_W-1:0]  pay_r [RD_LAT];

    // Shift stage 0 toward the output stage every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_r <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pay_r[k] <= '0;
            end
        end else begin
            vld_r[0] <= in_valid;
            pay_r[0] <= in_pay;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_r[k] <= vld_r[k-1];
                pay_r[k] <= pay_r[k-1];
            end
        end
    end

    assign out_valid = vld_r[RD_LAT-1];
    assign out_pay   = pay_r[RD_LAT-1];

    // Only stages behind the output count: the output stage is delivered this cycle.
    always_comb begin
        any_valid = 1'b0;
        for (int k = 0; k < RD_LAT - 1; k++) begin
            any_valid = any_valid | vld_r[k];
        end
    end

endmodule

// File: rtl/boid_sweep_ctrl.sv
// Frame sequencer for the boid-update datapath and boid register memory.
// For each boid i: clear accumulators, stream all j, finish update, write back.
module boid_sweep_ctrl
    import boid_sweep_pkg::*;
#(
    parameter  int N_BOIDS = 2,
    parameter  int RD_LAT  = 2,
    localparam int IDX_W   = idx_w(N_BOIDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             dp_ready,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_addr,
    output logic [IDX_W-1:0] cur_idx,
    output logic             dp_clr,
    output logic             dp_acc,
    output logic             dp_self,
    output logic             dp_fin,
    output logic             wr_en
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BOIDS - 1);

    sweep_state_t     state_r;
    sweep_state_t     state_s;
    logic [IDX_W-1:0] i_r;
    logic [IDX_W-1:0] j_r;
    logic             fin_seen_r;
    logic             rd_en_s;
    logic             self_s;
    logic             pipe_valid_s;
    logic             pipe_self_s;
    logic             pipe_pending_s;

    assign self_s = (j_r == i_r);

    rd_valid_pipe #(
        .RD_LAT (RD_LAT),
        .PAY_W  (1)
    ) u_rd_valid_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_en_s),
        .in_pay    (self_s),
        .out_valid (pipe_valid_s),
        .out_pay   (pipe_self_s),
        .any_valid (pipe_pending_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Boid indices and the UPDATE entry marker.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_r        <= '0;
            j_r        <= '0;
            fin_seen_r <= 1'b0;
        end else begin
            fin_seen_r <= (state_r == ST_UPDATE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        i_r <= '0;
                    end
                end
                ST_CLEAR: begin
                    j_r <= '0;
                end
                ST_SCAN: begin
                    if (!stall && (j_r != LAST_IDX)) begin
                        j_r <= j_r + IDX_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (i_r != LAST_IDX) begin
                        i_r <= i_r + IDX_W'(1);
                    end
                end
                default: begin
                    j_r <= j_r;
                end
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_s = ST_SCAN;
            end
            ST_SCAN: begin
                if (!stall && (j_r == LAST_IDX)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_DRAIN: begin
                if (!pipe_pending_s) begin
                    state_s = ST_UPDATE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_UPDATE: begin
                // dp_ready seen in the dp_fin cycle itself does not count.
                if (fin_seen_r && dp_ready) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_UPDATE;
                end
            end
            ST_WRITE: begin
                if (i_r == LAST_IDX) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode.
    always_comb begin
        rd_en_s = 1'b0;
        dp_clr  = 1'b0;
        dp_fin  = 1'b0;
        wr_en   = 1'b0;
        done    = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                dp_clr = 1'b1;
            end
            ST_SCAN: begin
                if (!stall) begin
                    rd_en_s = 1'b1;
                end else begin
                    rd_en_s = 1'b0;
                end
            end
            ST_UPDATE: begin
                if (!fin_seen_r) begin
                    dp_fin = 1'b1;
                end else begin
                    dp_fin = 1'b0;
                end
            end
            ST_WRITE: begin
                wr_en = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                rd_en_s = 1'b0;
            end
        endcase
    end

    assign busy    = (state_r != ST_IDLE);
    assign overrun = start & busy;
    assign rd_en   = rd_en_s;
    assign rd_addr = j_r;
    assign cur_idx = i_r;
    assign dp_acc  = pipe_valid_s;
    assign dp_self = pipe_valid_s & pipe_self_s;

endmodule

// File: tb/tb_boid_sweep_ctrl.sv
// Self-checking bench for boid_sweep_ctrl: a per-frame expected trace is
// built from the sequencing rules, then replayed against two configurations.
module tb_boid_sweep_ctrl;

    localparam int MAXT = 256;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic start_a = 1'b0, stall_a = 1'b0, rdy_a = 1'b0;
    logic start_b = 1'b0, stall_b = 1'b0, rdy_b = 1'b0;
    logic busy_a, done_a, over_a, rd_a, clr_a, acc_a, self_a, fin_a, wr_a;
    logic busy_b, done_b, over_b, rd_b, clr_b, acc_b, self_b, fin_b, wr_b;
    logic [0:0] addr_a, cur_a, addr_b, cur_b;

    logic o_busy, o_done, o_over, o_rd, o_clr, o_acc, o_self, o_fin, o_wr;
    logic [0:0] o_addr, o_cur;

    bit sel = 1'b0;
    int nvec = 0;
    int nfail = 0;

    bit st_start [MAXT];
    bit st_stall [MAXT];
    bit st_ready [MAXT];
    bit e_busy [MAXT];
    bit e_done [MAXT];
    bit e_over [MAXT];
    bit e_rd   [MAXT];
    bit e_clr  [MAXT];
    bit e_acc  [MAXT];
    bit e_self [MAXT];
    bit e_fin  [MAXT];
    bit e_wr   [MAXT];
    bit e_curv [MAXT];
    int e_addr [MAXT];
    int e_cur  [MAXT];
    int flen;

    always #5 clk = ~clk;

    boid_sweep_ctrl #(.N_BOIDS(2), .RD_LAT(2)) dut (
        .clk(clk), .reset(reset), .start(start_a), .stall(stall_a), .dp_ready(rdy_a),
        .busy(busy_a), .done(done_a), .overrun(over_a), .rd_en(rd_a), .rd_addr(addr_a),
        .cur_idx(cur_a), .dp_clr(clr_a), .dp_acc(acc_a), .dp_self(self_a),
        .dp_fin(fin_a), .wr_en(wr_a)
    );

    boid_sweep_ctrl #(.N_BOIDS(1), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start_b), .stall(stall_b), .dp_ready(rdy_b),
        .busy(busy_b), .done(done_b), .overrun(over_b), .rd_en(rd_b), .rd_addr(addr_b),
        .cur_idx(cur_b), .dp_clr(clr_b), .dp_acc(acc_b), .dp_self(self_b),
        .dp_fin(fin_b), .wr_en(wr_b)
    );

    always_comb begin
        o_busy = sel ? busy_b : busy_a;
        o_done = sel ? done_b : done_a;
        o_over = sel ? over_b : over_a;
        o_rd   = sel ? rd_b   : rd_a;
        o_clr  = sel ? clr_b  : clr_a;
        o_acc  = sel ? acc_b  : acc_a;
        o_self = sel ? self_b : self_a;
        o_fin  = sel ? fin_b  : fin_a;
        o_wr   = sel ? wr_b   : wr_a;
        o_addr = sel ? addr_b : addr_a;
        o_cur  = sel ? cur_b  : cur_a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v, input int cyc);
        nvec++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic drive(input bit s, input bit st, input bit r);
        if (sel) begin
            start_b = s; stall_b = st; rdy_b = r;
            start_a = 1'b0; stall_a = 1'b0; rdy_a = 1'b0;
        end else begin
            start_a = s; stall_a = st; rdy_a = r;
            start_b = 1'b0; stall_b = 1'b0; rdy_b = 1'b0;
        end
    endtask

    task automatic mark(input int t, input int i);
        e_busy[t] = 1'b1;
        e_cur[t]  = i;
        e_curv[t] = 1'b1;
    endtask

    // Expected trace of one frame; index 0 is the IDLE cycle that sees start.
    task automatic build(input int n, input int lat, input int smode, input int lmode, input bit snoise);
        int t, last, lt, done_t;
        bit first_rd;
        for (int k = 0; k < MAXT; k++) begin
            st_start[k] = 1'b0;
            st_stall[k] = (smode == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
            st_ready[k] = $urandom_range(0, 1) == 1;
            e_busy[k] = 0; e_done[k] = 0; e_over[k] = 0; e_rd[k] = 0; e_clr[k] = 0;
            e_acc[k] = 0; e_self[k] = 0; e_fin[k] = 0; e_wr[k] = 0; e_curv[k] = 0;
            e_addr[k] = 0; e_cur[k] = 0;
        end
        st_start[0] = 1'b1;
        t = 1;
        first_rd = 1'b1;
        for (int i = 0; i < n; i++) begin
            mark(t, i); e_clr[t] = 1'b1; t++;
            for (int j = 0; j < n; j++) begin
                while (st_stall[t] && t < MAXT - 60) begin
                    mark(t, i); t++;
                end
                st_stall[t] = 1'b0;
                mark(t, i);
                e_rd[t] = 1'b1; e_addr[t] = j;
                e_acc[t+lat] = 1'b1; e_self[t+lat] = (i == j);
                if (smode == 2 && first_rd) begin
                    st_stall[t+1] = 1'b1; st_stall[t+2] = 1'b1; st_stall[t+3] = 1'b1;
                    first_rd = 1'b0;
                end
                last = t; t++;
            end
            while (t < last + lat + 1) begin
                mark(t, i); t++;
            end
            lt = (lmode == 0) ? 1 : (lmode == 2) ? 10 : int'($urandom_range(1, 5));
            e_fin[t] = 1'b1;
            for (int k = 1; k < lt; k++) st_ready[t+k] = 1'b0;
            st_ready[t+lt] = 1'b1;
            for (int k = 0; k <= lt; k++) mark(t + k, i);
            t = t + lt + 1;
            mark(t, i); e_wr[t] = 1'b1; t++;
        end
        e_busy[t] = 1'b1; e_done[t] = 1'b1; done_t = t;
        flen = t + 4;
        if (snoise) begin
            for (int k = 1; k < done_t; k++) st_start[k] = ($urandom_range(0, 3) == 0);
            st_start[done_t] = 1'b1;
        end
        for (int k = 0; k < MAXT; k++) e_over[k] = st_start[k] && e_busy[k];
    endtask

    task automatic run_frame(input int n, input int lat, input int smode, input int lmode,
                             input bit snoise, input int done_at);
        int act_done;
        build(n, lat, smode, lmode, snoise);
        act_done = -1;
        for (int c = 0; c < flen; c++) begin
            @(posedge clk);
            #1 drive(st_start[c], st_stall[c], st_ready[c]);
            @(negedge clk);
            chk("busy",    o_busy, e_busy[c], c);
            chk("done",    o_done, e_done[c], c);
            chk("overrun", o_over, e_over[c], c);
            chk("rd_en",   o_rd,   e_rd[c],   c);
            chk("dp_clr",  o_clr,  e_clr[c],  c);
            chk("dp_acc",  o_acc,  e_acc[c],  c);
            chk("dp_self", o_self, e_self[c], c);
            chk("dp_fin",  o_fin,  e_fin[c],  c);
            chk("wr_en",   o_wr,   e_wr[c],   c);
            if (e_rd[c])   chk("rd_addr", o_addr, e_addr[c], c);
            if (e_curv[c]) chk("cur_idx", o_cur,  e_cur[c],  c);
            if (o_done === 1'b1 && act_done < 0) act_done = c;
        end
        if (done_at >= 0) chk("done_cycle", act_done, done_at, 0);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Reset asserted while boid 0 is reading j=1.
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_rst_rd_en", o_rd, 1'b1, 0);
        chk("pre_rst_addr",  o_addr, 1'b1, 0);
        reset = 1'b0;
        #1;
        chk("rst_busy", o_busy, 1'b0, 0);
        chk("rst_rd_en", o_rd, 1'b0, 0);
        chk("rst_addr", o_addr, 1'b0, 0);
        chk("rst_cur", o_cur, 1'b0, 0);
        chk("rst_outs", {o_done, o_over, o_clr, o_acc, o_self, o_fin, o_wr}, 7'd0, 0);
        @(negedge clk); reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("idle_busy", o_busy, 1'b0, k);
            chk("idle_rd_en", o_rd, 1'b0, k);
        end

        run_frame(2, 2, 0, 0, 1'b0, 17);
        run_frame(2, 2, 2, 0, 1'b0, 20);
        run_frame(2, 2, 0, 2, 1'b0, -1);
        run_frame(2, 2, 0, 1, 1'b1, -1);

        sel = 1'b1;
        run_frame(1, 1, 0, 0, 1'b0, 7);
        for (int r = 0; r < 6; r++) run_frame(1, 1, 1, 1, 1'b1, -1);

        sel = 1'b0;
        for (int r = 0; r < 15; r++) run_frame(2, 2, 1, 1, ($urandom_range(0, 1) == 1), -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
